// File: rtl/led_fade_driver_pkg.sv
// Shared constants and state encoding for the LED index sequencer and fade driver.
package led_pkg;

  localparam int LED_NUM   = 4;
  localparam int LED_IDX_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FADE = 1'b1
  } fade_state_e;

  function automatic logic [LED_NUM-1:0] idx_onehot(input logic [LED_IDX_W-1:0] idx);
    idx_onehot      = '0;
    idx_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/led_fade_driver_if.sv
// LED selection in, LED drive and fade status out.
interface led_fade_driver_if import led_pkg::*; ();

  logic [LED_IDX_W-1:0] led_sel;
  logic [LED_NUM-1:0]   led;
  logic                 busy;

  modport master (output led_sel, input led, input busy);
  modport slave  (input led_sel, output led, output busy);

endinterface

// File: rtl/led_fade_driver_pwm.sv
// Free-running PWM counter with two duty comparators (old and new LED channels).
module led_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PWM_BITS:0] duty_a,
  input  logic [PWM_BITS:0] duty_b,
  output logic              on_a,
  output logic              on_b
);

  logic [PWM_BITS-1:0] pwm_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pwm_cnt_q <= '0;
    else      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
  end

  // Zero-extended compare: duty 0 is never on, duty 2^PWM_BITS is always on.
  assign on_a = {1'b0, pwm_cnt_q} < duty_a;
  assign on_b = {1'b0, pwm_cnt_q} < duty_b;

endmodule

// File: rtl/led_fade_driver.sv
// Cross-fades the four board LEDs between successive led_sel indices using PWM.
module led_fade_driver import led_pkg::*; #(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 19_531,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic              clk,
  input  logic              rst,
  led_fade_driver_if.slave  bus
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS:0]   DUTY_FULL = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [LED_NUM-1:0]  LED_OFF   = (ACTIVE_LOW != 0) ? '1 : '0;

  fade_state_e          state_q, state_d;
  logic [LED_IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic [LED_IDX_W-1:0] tgt_idx_q, tgt_idx_d;
  logic [LED_IDX_W-1:0] pend_idx_q;
  logic [PWM_BITS:0]    duty_q, duty_d;
  logic [STEP_W-1:0]    step_cnt_q, step_cnt_d;
  logic [LED_NUM-1:0]   led_q, led_d;

  logic [PWM_BITS:0]    duty_b;
  logic                 on_a, on_b;
  logic [LED_NUM-1:0]   led_raw;

  // Complementary duty keeps old + new brightness at full scale.
  assign duty_b = DUTY_FULL - duty_q;

  led_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk    (clk),
    .rst    (rst),
    .duty_a (duty_q),
    .duty_b (duty_b),
    .on_a   (on_a),
    .on_b   (on_b)
  );

  always_comb begin
    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    tgt_idx_d  = tgt_idx_q;
    duty_d     = duty_q;
    step_cnt_d = step_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_idx_q != cur_idx_q) begin
          tgt_idx_d  = pend_idx_q;
          duty_d     = DUTY_FULL;
          step_cnt_d = '0;
          state_d    = ST_FADE;
        end
      end
      ST_FADE: begin
        // The cycle spent at duty 0 is the final step and hands over to the new LED.
        if (duty_q == '0) begin
          cur_idx_d  = tgt_idx_q;
          duty_d     = DUTY_FULL;
          step_cnt_d = '0;
          state_d    = ST_IDLE;
        end else if (step_cnt_q == STEP_LAST) begin
          step_cnt_d = '0;
          duty_d     = duty_q - (PWM_BITS + 1)'(1);
        end else begin
          step_cnt_d = step_cnt_q + STEP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    led_raw = idx_onehot(cur_idx_q) & {LED_NUM{on_a}};
    if (state_q == ST_FADE) led_raw = led_raw | (idx_onehot(tgt_idx_q) & {LED_NUM{on_b}});
    led_d = led_raw ^ LED_OFF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cur_idx_q  <= '0;
      tgt_idx_q  <= '0;
      pend_idx_q <= '0;
      duty_q     <= DUTY_FULL;
      step_cnt_q <= '0;
      led_q      <= LED_OFF;
    end else begin
      state_q    <= state_d;
      cur_idx_q  <= cur_idx_d;
      tgt_idx_q  <= tgt_idx_d;
      pend_idx_q <= bus.led_sel;
      duty_q     <= duty_d;
      step_cnt_q <= step_cnt_d;
      led_q      <= led_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.busy = (state_q == ST_FADE);

endmodule

// File: tb/tb_led_fade_driver.sv
// Scoreboard bench for led_fade_driver (PWM_BITS=3, STEP_CYCLES=2) plus an active-low instance.
module tb_led_fade_driver;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  led_fade_driver_if bus ();
  led_fade_driver_if bus2 ();

  led_fade_driver #(.PWM_BITS(3), .STEP_CYCLES(2), .ACTIVE_LOW(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  led_fade_driver #(.PWM_BITS(8), .STEP_CYCLES(2), .ACTIVE_LOW(1)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [4:0] exp_q[$];
  int fade_f[$];
  int fade_old[$];
  int fade_new[$];
  logic [4:0] mon_e;

  function automatic logic [3:0] oh(input int i);
    logic [3:0] r;
    r    = 4'b0000;
    r[i] = 1'b1;
    return r;
  endfunction

  // Expected {busy, led} after posedge number cyc since reset release.
  // A fade scheduled at F is in FADE after edges F..F+16; led lags the state by one edge.
  function automatic logic [4:0] expect_at(input int cyc);
    logic       b;
    logic [3:0] l;
    b = 1'b0;
    l = (cyc == 0) ? 4'b0000 : 4'b0001;
    for (int k = 0; k < fade_f.size(); k++) begin
      int j, d, p;
      j = cyc - 1 - fade_f[k];
      if (cyc >= fade_f[k] && cyc <= fade_f[k] + 16) b = 1'b1;
      if (j >= 0 && j <= 16) begin
        d = 8 - j / 2;
        p = (cyc - 1) % 8;
        l = ((p < d) ? oh(fade_old[k]) : 4'b0000) | ((p < 8 - d) ? oh(fade_new[k]) : 4'b0000);
      end else if (j > 16) begin
        l = oh(fade_new[k]);
      end
    end
    return {b, l};
  endfunction

  task automatic add_fade(input int f, input int o, input int nw);
    fade_f.push_back(f);
    fade_old.push_back(o);
    fade_new.push_back(nw);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) n++;
    #1;
  endtask

  task automatic push();
    if (!rst) exp_q.push_back(5'b00000);
    else      exp_q.push_back(expect_at(n));
  endtask

  task automatic run(input int k);
    repeat (k) begin
      tick();
      push();
    end
  endtask

  task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got busy=%b led=%b expected busy=%b led=%b", name, got[4], got[3:0], exp[4], exp[3:0]);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({bus.busy, bus.led} !== mon_e) begin
        errors++;
        $display("FAIL scoreboard cyc=%0d got busy=%b led=%b expected busy=%b led=%b",
                 n, bus.busy, bus.led, mon_e[4], mon_e[3:0]);
      end
    end
  end

  initial begin
    int f;
    int t;
    rst          = 1'b0;
    rst2         = 1'b0;
    bus.led_sel  = 2'd0;
    bus2.led_sel = 2'd3;

    // Reset held
    run(3);
    chk("al_reset", {bus2.busy, bus2.led}, 5'b01111);
    rst2 = 1'b1;

    // Release with led_sel=0, settle on LED 0
    tick(); rst = 1'b1; push();
    run(6);

    // Fade 0 -> 1
    tick(); bus.led_sel = 2'd1; add_fade(n + 2, 0, 1); push();
    run(24);

    // Fade 1 -> 2, switch request to 3 mid-fade, then fade 2 -> 3 after one idle cycle
    tick(); bus.led_sel = 2'd2; f = n + 2; add_fade(f, 1, 2); push();
    run(7);
    tick(); bus.led_sel = 2'd3; add_fade(f + 18, 2, 3); push();
    run(40);

    // Fade 3 -> 0 with a one-cycle 0->1->0 pulse during the fade
    tick(); bus.led_sel = 2'd0; add_fade(n + 2, 3, 0); push();
    run(6);
    tick(); bus.led_sel = 2'd1; push();
    tick(); bus.led_sel = 2'd0; push();
    run(30);

    // Fade 0 -> 2 aborted by reset halfway
    tick(); bus.led_sel = 2'd2; add_fade(n + 2, 0, 2); push();
    run(9);
    tick(); rst = 1'b0; bus.led_sel = 2'd0; n = 0;
    fade_f.delete(); fade_old.delete(); fade_new.delete();
    push();
    run(2);
    tick(); rst = 1'b1; push();
    run(10);

    // Active-low instance: long fade 0 -> 3, then idle on 3
    chk("al_busy_mid", {bus2.busy, 4'b0000}, 5'b10000);
    t = 0;
    while (bus2.busy && t < 2000) begin
      tick();
      t++;
    end
    checks++;
    if (bus2.busy) begin
      errors++;
      $display("FAIL al_fade_timeout got busy=1 expected busy=0 within 2000 cycles");
    end
    repeat (300) begin
      tick();
      chk("al_idle3", {bus2.busy, bus2.led}, 5'b00111);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
